pc_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction memory.
- Holds the program counter and drives the 10-bit byte address into the instruction memory.
- Selects the next PC from PC+4, branch, jump or jump-register.
- Captures the combinationally returned instruction into the IF/ID pipeline register, with stall, flush and halt handling.

---
 rtl/pc_fetch_unit_pkg.sv | 22 ++
 rtl/pc_fetch_unit_if.sv | 29 ++
 rtl/pc_next_sel.sv | 118 +++++++++++
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types and constants for pc_fetch_unit.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
package pc_fetch_unit_pkg;

  localparam int          ADDR_W_DEF    = 10;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  // Which redirect won the priority contest this cycle
  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_JR     = 2'd2,
    RD_JUMP   = 2'd3
  } redir_sel_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory and IF/ID bundle between fetch, imem and decode.
// master = fetch stage, slave = memory/decode side.
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] Read_Address;
  logic [31:0]       Instruction_In;
  logic [31:0]       IF_ID_Instruction;
  logic [ADDR_W-1:0] IF_ID_PC_Plus4;
  logic              IF_ID_Valid;

  modport master (
    output Read_Address,
    output IF_ID_Instruction,
    output IF_ID_PC_Plus4,
    output IF_ID_Valid,
    input  Instruction_In
  );

  modport slave (
    input  Read_Address,
    input  IF_ID_Instruction,
    input  IF_ID_PC_Plus4,
    input  IF_ID_Valid,
    output Instruction_In
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux and IF/ID load control.
// Priority: halted freeze > redirect > stall > halt word > PC+4.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc,
  input  fetch_state_t      state,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [31:0]       jr_address,
  input  logic              halt_hit,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              load_valid,
  output logic              load_bubble,
  output logic              hold,
  output logic              take_redirect,
  output logic              enter_halt
);

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] redir_tgt;
  redir_sel_t        redir_sel;

  logic in_run;
  logic any_redir;
  logic c_redir;
  logic c_hold;
  logic c_halt;
  logic c_adv;
  logic c_idle;

  // Target bits above ADDR_W and below word alignment are dropped
  logic unused_bits;
  assign unused_bits = ^{jump_index[25:ADDR_W-2],
                         jr_address[31:ADDR_W],
                         jr_address[1:0],
                         branch_target[1:0]};

  assign br_tgt   = {branch_target[ADDR_W-1:2], 2'b00};
  assign j_tgt    = {jump_index[ADDR_W-3:0], 2'b00};
  assign jr_tgt   = {jr_address[ADDR_W-1:2], 2'b00};
  assign pc_plus4 = pc + ADDR_W'(4);

  assign in_run    = (state == ST_RUN);
  assign any_redir = branch_taken | jump | jr;

  always_comb begin
    redir_sel = RD_NONE;
    unique case (1'b1)
      branch_taken:       redir_sel = RD_BRANCH;
      (!branch_taken&&jr): redir_sel = RD_JR;
      (!branch_taken&&!jr&&jump):
                          redir_sel = RD_JUMP;
      default:            redir_sel = RD_NONE;
    endcase
  end

  always_comb begin
    redir_tgt = pc;
    unique case (redir_sel)
      RD_BRANCH: redir_tgt = br_tgt;
      RD_JR:     redir_tgt = jr_tgt;
      RD_JUMP:   redir_tgt = j_tgt;
      default:   redir_tgt = pc;
    endcase
  end

  assign c_redir = in_run && any_redir;
  assign c_hold  = stall && !c_redir;
  assign c_halt  = in_run && !any_redir
                 && !stall && halt_hit;
  assign c_adv   = in_run && !any_redir
                 && !stall && !halt_hit;
  assign c_idle  = !in_run && !stall;

  always_comb begin
    next_pc       = pc;
    load_valid    = 1'b0;
    load_bubble   = 1'b0;
    hold          = 1'b0;
    take_redirect = 1'b0;
    enter_halt    = 1'b0;
    unique case (1'b1)
      c_redir: begin
        next_pc       = redir_tgt;
        load_bubble   = 1'b1;
        take_redirect = 1'b1;
      end
      c_hold: begin
        hold = 1'b1;
      end
      c_halt: begin
        load_bubble = 1'b1;
        enter_halt  = 1'b1;
      end
      c_adv: begin
        next_pc    = pc_plus4;
        load_valid = 1'b1;
      end
      c_idle: begin
        load_bubble = 1'b1;
      end
      default: begin
        hold = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register, imem address, IF/ID register, halt FSM.
// Define FETCH_PERF_CNT_EN to add Fetch_Count / Flush_Count outputs.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  input  logic              Jump,
  input  logic [25:0]       Jump_Index,
  input  logic              Jr,
  input  logic [31:0]       Jr_Address,
  pc_fetch_unit_if.master   bus,
  output logic              Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       Fetch_Count,
  output logic [15:0]       Flush_Count
`endif
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [31:0]       ifid_instr_q;
  logic [ADDR_W-1:0] ifid_pc4_q;
  logic              ifid_valid_q;

  logic halt_hit;
  logic load_valid;
  logic load_bubble;
  logic hold;
  logic take_redirect;
  logic enter_halt;

  assign halt_hit = (bus.Instruction_In == HALT_WORD);

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_next_sel (
    .pc            (pc_q),
    .state         (state_q),
    .stall         (Stall),
    .branch_taken  (Branch_Taken),
    .branch_target (Branch_Target),
    .jump          (Jump),
    .jump_index    (Jump_Index),
    .jr            (Jr),
    .jr_address    (Jr_Address),
    .halt_hit      (halt_hit),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .load_valid    (load_valid),
    .load_bubble   (load_bubble),
    .hold          (hold),
    .take_redirect (take_redirect),
    .enter_halt    (enter_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // HALTED is sticky; only reset leaves it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (enter_halt) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (!hold) begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else if (load_valid) begin
      ifid_instr_q <= bus.Instruction_In;
      ifid_pc4_q   <= pc_plus4;
      ifid_valid_q <= 1'b1;
    end else if (load_bubble) begin
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fetch_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (load_valid && (Fetch_Count != '1))
        Fetch_Count <= Fetch_Count + 32'd1;
      if (take_redirect && (Flush_Count != '1))
        Flush_Count <= Flush_Count + 16'd1;
    end
  end
`endif

  assign bus.Read_Address      = pc_q;
  assign bus.IF_ID_Instruction = ifid_instr_q;
  assign bus.IF_ID_PC_Plus4    = ifid_pc4_q;
  assign bus.IF_ID_Valid       = ifid_valid_q;
  assign Halted                = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit with a small imem model.
// Perf counters are checked only when FETCH_PERF_CNT_EN is defined.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [9:0]  bt;
  logic        jmp;
  logic [25:0] ji;
  logic        jr;
  logic [31:0] ja;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  logic [31:0] mem [256];

  int applied = 0;
  int errs    = 0;

  pc_fetch_unit_if #(.ADDR_W(10)) bus ();

  assign bus.Instruction_In = mem[bus.Read_Address[9:2]];

  pc_fetch_unit #(
    .ADDR_W    (10),
    .RESET_PC  (10'h000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Stall         (stall),
    .Branch_Taken  (br),
    .Branch_Target (bt),
    .Jump          (jmp),
    .Jump_Index    (ji),
    .Jr            (jr),
    .Jr_Address    (ja),
    .bus           (bus),
    .Halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Fetch_Count   (fetch_cnt),
    .Flush_Count   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [9:0]  bt;
    logic        jmp;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] ja;
    logic [9:0]  e_ra;
    logic [31:0] e_ins;
    logic [9:0]  e_pc4;
    logic        e_v;
    logic        e_h;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(
    input logic s, input logic b, input logic [9:0] t,
    input logic j, input logic [25:0] i,
    input logic r, input logic [31:0] a,
    input logic [9:0] ra, input logic [31:0] ins,
    input logic [9:0] p4, input logic v, input logic h);
    vec_t x;
    x.stall = s; x.br = b; x.bt = t;
    x.jmp = j; x.ji = i; x.jr = r; x.ja = a;
    x.e_ra = ra; x.e_ins = ins; x.e_pc4 = p4;
    x.e_v = v; x.e_h = h;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [9:0] ra, input logic [31:0] ins,
                     input logic [9:0] p4, input logic v,
                     input logic h);
    applied++;
    if (bus.Read_Address !== ra || bus.IF_ID_Instruction !== ins ||
        bus.IF_ID_PC_Plus4 !== p4 || bus.IF_ID_Valid !== v ||
        halted !== h) begin
      errs++;
      $display("FAIL %s: got ra=%h ins=%h pc4=%h v=%b h=%b want ra=%h ins=%h pc4=%h v=%b h=%b",
               nm, bus.Read_Address, bus.IF_ID_Instruction,
               bus.IF_ID_PC_Plus4, bus.IF_ID_Valid, halted,
               ra, ins, p4, v, h);
    end
  endtask

  task automatic idle_in();
    stall = 0; br = 0; bt = '0; jmp = 0;
    ji = '0; jr = 0; ja = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0;
    mem[3] = 32'h0;
    mem[8] = 32'hFFFF_FFFF;

    //          st br bt      j  ji        jr ja            ra      ins           pc4     v  h
    vt[0]  = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h004, 32'h2008_0001, 10'h004, 1, 0);
    vt[1]  = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h008, 32'h2009_0002, 10'h008, 1, 0);
    vt[2]  = mk(1, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h008, 32'h2009_0002, 10'h008, 1, 0);
    vt[3]  = mk(1, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h008, 32'h2009_0002, 10'h008, 1, 0);
    vt[4]  = mk(1, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h008, 32'h2009_0002, 10'h008, 1, 0);
    vt[5]  = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h00C, 32'h0,         10'h00C, 1, 0);
    vt[6]  = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h010, 32'h0,         10'h010, 1, 0);
    vt[7]  = mk(1, 1, 10'h3F1,0, 26'h0,    0, 32'h0,        10'h3F0, 32'h0,         10'h000, 0, 0);
    vt[8]  = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h3F4, 32'h1000_00FC, 10'h3F4, 1, 0);
    vt[9]  = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h3F8, 32'h1000_00FD, 10'h3F8, 1, 0);
    vt[10] = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h3FC, 32'h1000_00FE, 10'h3FC, 1, 0);
    vt[11] = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h000, 32'h1000_00FF, 10'h000, 1, 0);
    vt[12] = mk(0, 1, 10'h085,1, 26'h40,   1, 32'h100,      10'h084, 32'h0,         10'h000, 0, 0);
    vt[13] = mk(0, 0, 10'h0,  1, 26'h40,   1, 32'h100,      10'h100, 32'h0,         10'h000, 0, 0);
    vt[14] = mk(0, 0, 10'h0,  1, 26'h41,   1, 32'hFFFF_F20B,10'h208, 32'h0,         10'h000, 0, 0);
    vt[15] = mk(0, 0, 10'h0,  1, 26'h3FF07,0, 32'h0,        10'h01C, 32'h0,         10'h000, 0, 0);
    vt[16] = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h020, 32'h1000_0007, 10'h020, 1, 0);
    vt[17] = mk(1, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h020, 32'h1000_0007, 10'h020, 1, 0);
    vt[18] = mk(0, 1, 10'h01D,0, 26'h0,    0, 32'h0,        10'h01C, 32'h0,         10'h000, 0, 0);
    vt[19] = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h020, 32'h1000_0007, 10'h020, 1, 0);
    vt[20] = mk(0, 0, 10'h0,  0, 26'h0,    0, 32'h0,        10'h020, 32'h0,         10'h000, 0, 1);
    vt[21] = mk(0, 0, 10'h0,  1, 26'h10,   0, 32'h0,        10'h020, 32'h0,         10'h000, 0, 1);
    vt[22] = mk(1, 0, 10'h0,  0, 26'h0,    1, 32'h40,       10'h020, 32'h0,         10'h000, 0, 1);
    vt[23] = mk(0, 1, 10'h100,0, 26'h0,    0, 32'h0,        10'h020, 32'h0,         10'h000, 0, 1);

    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 10'h000, 32'h0, 10'h000, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    applied++;
    if (fetch_cnt !== 0 || flush_cnt !== 0) begin
      errs++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", fetch_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 24; k++) begin
      stall = vt[k].stall; br = vt[k].br; bt = vt[k].bt;
      jmp = vt[k].jmp; ji = vt[k].ji;
      jr = vt[k].jr; ja = vt[k].ja;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", k), vt[k].e_ra, vt[k].e_ins,
          vt[k].e_pc4, vt[k].e_v, vt[k].e_h);
    end
    idle_in();

`ifdef FETCH_PERF_CNT_EN
    applied++;
    if (fetch_cnt !== 32'd10 || flush_cnt !== 16'd6) begin
      errs++;
      $display("FAIL perf_counts: got %0d/%0d want 10/6", fetch_cnt, flush_cnt);
    end
`endif

    // asynchronous reset out of HALTED, checked between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 10'h000, 32'h0, 10'h000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_fetch", 10'h004, 32'h2008_0001, 10'h004, 1'b1, 1'b0);

    // redirect then stall: bubble holds through the stall
    jmp = 1; ji = 26'h3;
    @(posedge clk);
    #1;
    idle_in();
    chk("jump_bubble", 10'h00C, 32'h0, 10'h000, 1'b0, 1'b0);
    stall = 1;
    @(posedge clk);
    #1;
    chk("stall_on_bubble", 10'h00C, 32'h0, 10'h000, 1'b0, 1'b0);
    stall = 0;
    @(posedge clk);
    #1;
    chk("after_penalty", 10'h010, 32'h0, 10'h010, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
